// File: rtl/if_stage_if.sv
// Instruction-memory request/ack bus between the fetch stage (master) and memory (slave).
interface if_stage_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;

  modport master (output imem_req_o, output imem_addr_o,
                  input  imem_ack_i, input  imem_rdata_i);
  modport slave  (input  imem_req_o, input  imem_addr_o,
                  output imem_ack_i, output imem_rdata_i);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IDLE/REQ/HOLD fetch FSM and IF/ID pipeline register.
// Optional fetch timeout watchdog enabled by defining IF_FETCH_TIMEOUT_EN.
module if_stage (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [31:0]       flush_pc_i,
  if_stage_if.master        imem,
  output logic [31:0]       id_pc_o,
  output logic [31:0]       id_inst_o,
  output logic              id_valid_o,
  output logic              fetch_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] id_pc_n, id_inst_n;
  logic        id_valid_n;
  logic [31:0] hold_pc, hold_pc_n, hold_inst, hold_inst_n;

`ifdef IF_FETCH_TIMEOUT_EN
  logic [3:0]  cnt, cnt_n;
  logic        err_n;
`endif

  assign imem.imem_req_o  = (state == REQ);
  assign imem.imem_addr_o = pc;

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    id_pc_n     = id_pc_o;
    id_inst_n   = id_inst_o;
    id_valid_n  = id_valid_o;
    hold_pc_n   = hold_pc;
    hold_inst_n = hold_inst;
`ifdef IF_FETCH_TIMEOUT_EN
    cnt_n       = cnt;
    err_n       = 1'b0;
`endif

    if (flush_i) begin
      // Redirect wins over stall and ack; an in-flight ack is dropped.
      pc_n        = {flush_pc_i[31:2], 2'b00};
      id_valid_n  = 1'b0;
      id_inst_n   = '0;
      hold_pc_n   = '0;
      hold_inst_n = '0;
      state_n     = REQ;
`ifdef IF_FETCH_TIMEOUT_EN
      cnt_n       = '0;
`endif
    end else begin
      unique case (state)
        IDLE: state_n = REQ;
        REQ: begin
          if (imem.imem_ack_i) begin
            pc_n = pc + 32'd4;
`ifdef IF_FETCH_TIMEOUT_EN
            cnt_n = '0;
`endif
            if (stall_i) begin
              hold_pc_n   = pc;
              hold_inst_n = imem.imem_rdata_i;
              state_n     = HOLD;
            end else begin
              id_pc_n    = pc;
              id_inst_n  = imem.imem_rdata_i;
              id_valid_n = 1'b1;
            end
          end else begin
            if (!stall_i) begin
              id_valid_n = 1'b0;
              id_inst_n  = '0;
            end
`ifdef IF_FETCH_TIMEOUT_EN
            // Give up on a silent memory and refetch the same pc via IDLE.
            if (cnt == 4'd15) begin
              err_n   = 1'b1;
              cnt_n   = '0;
              state_n = IDLE;
            end else begin
              cnt_n = cnt + 4'd1;
            end
`endif
          end
        end
        HOLD: begin
          if (!stall_i) begin
            id_pc_n    = hold_pc;
            id_inst_n  = hold_inst;
            id_valid_n = 1'b1;
            state_n    = REQ;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= '0;
      id_pc_o    <= '0;
      id_inst_o  <= '0;
      id_valid_o <= 1'b0;
      hold_pc    <= '0;
      hold_inst  <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      id_pc_o    <= id_pc_n;
      id_inst_o  <= id_inst_n;
      id_valid_o <= id_valid_n;
      hold_pc    <= hold_pc_n;
      hold_inst  <= hold_inst_n;
    end
  end

`ifdef IF_FETCH_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      fetch_err_o <= 1'b0;
    end else begin
      cnt         <= cnt_n;
      fetch_err_o <= err_n;
    end
  end
`else
  assign fetch_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage: streaming, bubbles, stall/hold, flush, wrap, reset, timeout.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i;
  logic [31:0] flush_pc_i;
  logic [31:0] id_pc_o, id_inst_o;
  logic        id_valid_o, fetch_err_o;
  int          errors = 0;
  int          checks = 0;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  if_stage_if imem_bus ();

  if_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .flush_pc_i (flush_pc_i),
    .imem       (imem_bus),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o),
    .id_valid_o (id_valid_o),
    .fetch_err_o(fetch_err_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ack, input logic [31:0] addr, input logic stall,
                       input logic flush, input logic [31:0] fpc);
    imem_bus.imem_ack_i   = ack;
    imem_bus.imem_rdata_i = addr ^ KEY;
    stall_i               = stall;
    flush_i               = flush;
    flush_pc_i            = fpc;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(); step();
    check("rst_valid", id_valid_o, 1'b0);
    check("rst_pc", id_pc_o, 32'h0);
    check("rst_inst", id_inst_o, 32'h0);
    check("rst_req", imem_bus.imem_req_o, 1'b0);
    check("rst_err", fetch_err_o, 1'b0);

    rst = 1'b0;
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    step();                                   // IDLE -> REQ
    check("first_req", imem_bus.imem_req_o, 1'b1);
    check("first_addr", imem_bus.imem_addr_o, 32'h0);

    step();                                   // ack addr 0
    check("s0_valid", id_valid_o, 1'b1);
    check("s0_pc", id_pc_o, 32'h0);
    check("s0_inst", id_inst_o, 32'hA5A5_0000);
    check("s0_addr", imem_bus.imem_addr_o, 32'h4);
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
    step();
    check("s4_pc", id_pc_o, 32'h4);
    check("s4_inst", id_inst_o, 32'hA5A5_0004);
    check("s4_addr", imem_bus.imem_addr_o, 32'h8);

    drive(1'b0, 32'h8, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bub_valid", id_valid_o, 1'b0);
      check("bub_inst", id_inst_o, 32'h0);
      check("bub_pc", id_pc_o, 32'h4);
      check("bub_addr", imem_bus.imem_addr_o, 32'h8);
    end
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
    step();
    check("d8_pc", id_pc_o, 32'h8);
    check("d8_inst", id_inst_o, 32'hA5A5_0008);
    check("d8_valid", id_valid_o, 1'b1);
    drive(1'b1, 32'hC, 1'b0, 1'b0, 32'h0);
    step();
    check("dC_pc", id_pc_o, 32'hC);
    check("dC_addr", imem_bus.imem_addr_o, 32'h10);

    drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h0);
    step();                                   // ack while stalled -> HOLD
    drive(1'b0, 32'h10, 1'b1, 1'b0, 32'h0);
    check("h_req", imem_bus.imem_req_o, 1'b0);
    check("h_pc", id_pc_o, 32'hC);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hs_req", imem_bus.imem_req_o, 1'b0);
      check("hs_pc", id_pc_o, 32'hC);
      check("hs_valid", id_valid_o, 1'b1);
    end
    drive(1'b0, 32'h14, 1'b0, 1'b0, 32'h0);
    step();                                   // release
    check("rel_pc", id_pc_o, 32'h10);
    check("rel_inst", id_inst_o, 32'hA5A5_0010);
    check("rel_valid", id_valid_o, 1'b1);
    check("rel_addr", imem_bus.imem_addr_o, 32'h14);
    check("rel_req", imem_bus.imem_req_o, 1'b1);
    step();
    check("rel_once_valid", id_valid_o, 1'b0);
    check("rel_once_pc", id_pc_o, 32'h10);

    drive(1'b1, 32'h14, 1'b0, 1'b1, 32'h0000_0103);
    step();                                   // flush with ack
    check("fl_addr", imem_bus.imem_addr_o, 32'h100);
    check("fl_req", imem_bus.imem_req_o, 1'b1);
    check("fl_valid", id_valid_o, 1'b0);
    check("fl_pc", id_pc_o, 32'h10);
    drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    step();
    check("f100_pc", id_pc_o, 32'h100);
    check("f100_inst", id_inst_o, 32'hA5A5_0100);

    drive(1'b1, 32'h104, 1'b1, 1'b0, 32'h0);
    step();                                   // into HOLD with 0x104
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0200);
    step();                                   // flush discards hold
    check("fh_addr", imem_bus.imem_addr_o, 32'h200);
    check("fh_req", imem_bus.imem_req_o, 1'b1);
    check("fh_valid", id_valid_o, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    check("fh_drop_valid", id_valid_o, 1'b0);
    check("fh_drop_pc", id_pc_o, 32'h100);

    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    step();
    check("wr_addr", imem_bus.imem_addr_o, 32'hFFFF_FFFC);
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    step();
    check("wr_pc", id_pc_o, 32'hFFFF_FFFC);
    check("wr_inst", id_inst_o, 32'h5A5A_FFFC);
    check("wr_next", imem_bus.imem_addr_o, 32'h0);

    rst = 1'b1;
    drive(1'b1, 32'h0, 1'b1, 1'b1, 32'h0000_0400);
    step();
    check("rr_valid", id_valid_o, 1'b0);
    check("rr_pc", id_pc_o, 32'h0);
    check("rr_req", imem_bus.imem_req_o, 1'b0);
    check("rr_addr", imem_bus.imem_addr_o, 32'h0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    check("rr_req2", imem_bus.imem_req_o, 1'b1);
    check("rr_addr2", imem_bus.imem_addr_o, 32'h0);

`ifdef IF_FETCH_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      step();
      check("to_wait_err", fetch_err_o, 1'b0);
      check("to_wait_req", imem_bus.imem_req_o, 1'b1);
    end
    step();
    check("to_err", fetch_err_o, 1'b1);
    check("to_idle", imem_bus.imem_req_o, 1'b0);
    step();
    check("to_err_clr", fetch_err_o, 1'b0);
    check("to_rereq", imem_bus.imem_req_o, 1'b1);
    check("to_readdr", imem_bus.imem_addr_o, 32'h0);
`else
    for (int i = 0; i < 20; i++) begin
      step();
      check("nto_err", fetch_err_o, 1'b0);
    end
    check("nto_req", imem_bus.imem_req_o, 1'b1);
    check("nto_addr", imem_bus.imem_addr_o, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
